// File: rtl/mux_nway_stream_chip.sv
`default_nettype none
// ============================================================================
// Module   : mux_nway_stream_chip
// Purpose  : N-channel, WIDTH-bit stream multiplexer with a single registered
//            output slot and valid/ready handshaking on every channel.
//
//            The channel is chosen either by an external select
//            (mode = 0) or by a fair round-robin arbiter (mode = 1).
//
// Ports    : clk        rising-edge clock
//            rst_n      asynchronous active-low reset
//            out        registered output word
//            out_valid  out holds a valid word
//            out_ready  consumer accepts out this cycle
//            out_sel    channel that supplied the current out
//            in_data    flattened inputs, channel k at [k*WIDTH +: WIDTH]
//            in_valid   per-channel valid
//            in_ready   per-channel ready (combinational)
//            sel        channel select, fixed mode only
//            mode       0 = fixed select, 1 = round-robin
//
// Revision : 1.0 - initial release
// ============================================================================
module mux_nway_stream_chip #(
    parameter int WIDTH  = 16,
    parameter int NUM_CH = 8,
    parameter int SEL_W  = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic [WIDTH-1:0]        out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_sel,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    mode
);

    // One extra bit so that NUM_CH == 2**SEL_W is representable.
    localparam logic [SEL_W:0]   c_num_ch  = (SEL_W+1)'(NUM_CH);
    localparam logic [SEL_W-1:0] c_last_ch = SEL_W'(NUM_CH - 1);

    // ------------------------------------------------------------------------
    // Output slot and round-robin pointer
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] r_out;
    logic             r_valid;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] r_ptr;

    // ------------------------------------------------------------------------
    // Combinational grant path
    // ------------------------------------------------------------------------
    logic              w_load_en;
    logic              w_fix_has;
    logic              w_rr_has;
    logic [SEL_W-1:0]  w_rr_cand;
    logic              w_has;
    logic [SEL_W-1:0]  w_cand;
    logic [NUM_CH-1:0] w_ch_xfer;
    logic              w_xfer;
    logic [WIDTH-1:0]  w_data;

    // The slot can take a new word when empty or when its word leaves now;
    // this is what allows one word per cycle with no bubble.
    assign w_load_en = !r_valid || out_ready;

    // Codes at or above NUM_CH select nothing.
    assign w_fix_has = ({1'b0, sel} < c_num_ch);

    // Round-robin search: offsets are scanned from the farthest back to the
    // nearest, so the last hit written is the first valid channel at or
    // after the pointer in wrap-around order.
    always_comb begin
        int v_idx;
        v_idx     = 0;
        w_rr_has  = 1'b0;
        w_rr_cand = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            v_idx = int'(r_ptr) + i;
            if (v_idx >= NUM_CH) begin
                v_idx = v_idx - NUM_CH;
            end
            for (int k = 0; k < NUM_CH; k++) begin
                if ((k == v_idx) && in_valid[k]) begin
                    w_rr_has  = 1'b1;
                    w_rr_cand = SEL_W'(k);
                end
            end
        end
    end

    // Mode acts on the grant immediately; the held word is not affected.
    assign w_has  = mode ? w_rr_has  : w_fix_has;
    assign w_cand = mode ? w_rr_cand : sel;

    // In fixed mode ready is offered to sel regardless of its valid.
    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
            assign in_ready[k]  = w_has && w_load_en && (w_cand == SEL_W'(k));
            assign w_ch_xfer[k] = in_ready[k] && in_valid[k];
        end
    endgenerate

    assign w_xfer = |w_ch_xfer;

    // Data select: a pure copy of the candidate channel.
    always_comb begin
        w_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_cand == SEL_W'(k)) begin
                w_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output slot
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out   <= '0;
            r_valid <= 1'b0;
            r_sel   <= '0;
        end else if (w_xfer) begin
            r_out   <= w_data;
            r_sel   <= w_cand;
            r_valid <= 1'b1;
        end else if (r_valid && out_ready) begin
            // Drain without refill: data and index keep their last values.
            r_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Round-robin pointer: moves past the granted channel, and only on a
    // round-robin transfer, so it survives fixed-mode periods untouched.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_xfer && mode) begin
            r_ptr <= (w_cand == c_last_ch) ? '0 : w_cand + 1'b1;
        end
    end

    assign out       = r_out;
    assign out_valid = r_valid;
    assign out_sel   = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_mux_nway_stream_chip.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_nway_stream_chip
// Purpose  : Self-checking bench for mux_nway_stream_chip. A main instance
//            (8 x 16 bit) is compared every cycle against a transaction-level
//            model; a second instance (6 channels) covers unused sel codes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_nway_stream_chip;

    localparam int c_w  = 16;
    localparam int c_n  = 8;
    localparam int c_sw = 3;
    localparam int c_n6 = 6;

    logic                 clk;
    logic                 rst_n;
    logic [c_w-1:0]       out;
    logic                 out_valid;
    logic                 out_ready;
    logic [c_sw-1:0]      out_sel;
    logic [c_n*c_w-1:0]   in_data;
    logic [c_n-1:0]       in_valid;
    logic [c_n-1:0]       in_ready;
    logic [c_sw-1:0]      sel;
    logic                 mode;

    logic [c_w-1:0]       out6;
    logic                 out_valid6;
    logic                 out_ready6;
    logic [c_sw-1:0]      out_sel6;
    logic [c_n6*c_w-1:0]  in_data6;
    logic [c_n6-1:0]      in_valid6;
    logic [c_n6-1:0]      in_ready6;
    logic [c_sw-1:0]      sel6;
    logic                 mode6;

    mux_nway_stream_chip #(.WIDTH(c_w), .NUM_CH(c_n), .SEL_W(c_sw)) dut (
        .clk(clk), .rst_n(rst_n), .out(out), .out_valid(out_valid),
        .out_ready(out_ready), .out_sel(out_sel), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .sel(sel), .mode(mode)
    );

    mux_nway_stream_chip #(.WIDTH(c_w), .NUM_CH(c_n6), .SEL_W(c_sw)) dut6 (
        .clk(clk), .rst_n(rst_n), .out(out6), .out_valid(out_valid6),
        .out_ready(out_ready6), .out_sel(out_sel6), .in_data(in_data6),
        .in_valid(in_valid6), .in_ready(in_ready6), .sel(sel6), .mode(mode6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: one output slot plus a "next channel to favour".
    // ------------------------------------------------------------------------
    logic [c_w-1:0] m_out;
    logic           m_valid;
    int             m_sel;
    int             m_ptr;

    task automatic model_reset();
        m_out = '0; m_valid = 1'b0; m_sel = 0; m_ptr = 0;
    endtask

    // Who would be granted with the current inputs, and would it move a word.
    task automatic model_grant(output bit has, output int cand, output bit xfer,
                               output logic [c_n-1:0] rdy);
        bit room;
        has = 0; cand = 0;
        if (mode == 1'b0) begin
            if (int'(sel) < c_n) begin has = 1; cand = int'(sel); end
        end else begin
            for (int i = 0; i < c_n; i++) begin
                int k;
                k = (m_ptr + i) % c_n;
                if (!has && in_valid[k]) begin has = 1; cand = k; end
            end
        end
        room = !m_valid || out_ready;
        rdy  = (has && room) ? c_n'(1) << cand : '0;
        xfer = has && room && in_valid[cand];
    endtask

    // One clock: check ready before the edge, outputs after it.
    task automatic cycle();
        bit has; int cand; bit xfer; logic [c_n-1:0] rdy;
        #1;
        model_grant(has, cand, xfer, rdy);
        chk("in_ready", 32'(in_ready), 32'(rdy));
        @(posedge clk);
        if (xfer) begin
            m_out   = in_data[cand*c_w +: c_w];
            m_sel   = cand;
            m_valid = 1'b1;
            if (mode) m_ptr = (cand + 1) % c_n;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out", 32'(out), 32'(m_out));
        chk("out_sel", 32'(out_sel), 32'(m_sel));
    endtask

    initial begin
        int rr_seq [8] = '{0, 2, 5, 7, 0, 2, 5, 7};

        rst_n = 1'b0; out_ready = 1'b1; mode = 1'b0; sel = '0;
        in_valid = '0; in_data = '0;
        out_ready6 = 1'b1; mode6 = 1'b0; sel6 = 3'd7; in_valid6 = '1;
        in_data6 = {6{16'hBEEF}};
        model_reset();
        #2;
        chk("rst_out", 32'(out), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_sel", 32'(out_sel), 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Fixed sweep, channel k carries 16'h8000 >> k.
        for (int k = 0; k < c_n; k++) in_data[k*c_w +: c_w] = 16'h8000 >> k;
        in_valid = '1;
        for (int s = 0; s < c_n; s++) begin
            sel = c_sw'(s);
            cycle();
            chk("sweep_out", 32'(out), 32'(16'h8000 >> s));
            chk("sweep_sel", 32'(out_sel), s);
        end

        // 6-channel instance: sel = 7 selects nothing.
        chk("ch6_invalid_ready", 32'(in_ready6), 0);
        chk("ch6_invalid_valid", 32'(out_valid6), 0);
        sel6 = 3'd5;
        #1;
        chk("ch6_sel5_ready", 32'(in_ready6), 32'h20);
        @(posedge clk); #1;
        chk("ch6_sel5_valid", 32'(out_valid6), 1);
        chk("ch6_sel5_out_sel", 32'(out_sel6), 5);

        // Back-pressure for 3 cycles after a load.
        sel = 3'd2; cycle();
        out_ready = 1'b0; sel = 3'd6;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_out", 32'(out), 32'h2000);
        end
        out_ready = 1'b1;
        cycle();

        // Asynchronous reset mid-stream, between clock edges.
        chk("pre_rst_valid", 32'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out", 32'(out), 0);
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_out_sel", 32'(out_sel), 0);
        chk("arst_ptr", 32'(dut.r_ptr), 0);
        model_reset();
        #1 rst_n = 1'b1;

        // Round-robin fairness with a sparse constant pattern.
        mode = 1'b1; in_valid = 8'b1010_0101;
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("rr_seq", 32'(out_sel), rr_seq[i]);
            chk("rr_nobubble", 32'(out_valid), 1);
        end

        // Wrap-around: grant 6 (pointer 7), then only channel 1 valid.
        in_valid = 8'b0100_0000; cycle();
        chk("wrap_g6", 32'(out_sel), 6);
        in_valid = 8'b0000_0010; cycle();
        chk("wrap_g1", 32'(out_sel), 1);
        in_valid = '0; cycle();
        chk("drain_valid", 32'(out_valid), 0);
        in_valid = '1; cycle();
        chk("ptr_after_wrap", 32'(out_sel), 2);

        // Mode switch: grant 3, two fixed transfers from 5, back to rr.
        in_valid = 8'b0000_1000; cycle();
        chk("ms_g3", 32'(out_sel), 3);
        mode = 1'b0; sel = 3'd5; in_valid = '1;
        cycle(); cycle();
        chk("ms_fixed", 32'(out_sel), 5);
        mode = 1'b1; cycle();
        chk("ms_rr_resume", 32'(out_sel), 4);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            in_valid  = c_n'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            mode      = 1'($urandom);
            sel       = c_sw'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_nway_stream_chip.md
Name: mux_nway_stream_chip

Overview:
- Parametrised N-channel, W-bit stream multiplexer with a registered output stage and valid/ready handshaking on every channel.
- Successor to the combinational 8-way 16-bit mux, generalised in width and channel count.
- Adds two selection modes:
  - Fixed mode: the channel is chosen by an external sel.
  - Round-robin mode: a fair internal arbiter chooses the channel.
- Used wherever several producers share one consumer, e.g. register-file read ports or bus sources feeding the ALU path.

Parameters:
- WIDTH, 16, data width per channel in bits (>=1).
- NUM_CH, 8, number of input channels (2..16).
- SEL_W, 3, select/pointer width in bits; NUM_CH <= 2**SEL_W is required.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- out  output  WIDTH  registered output data.
- out_valid  output  1  out holds a valid word.
- out_ready  input  1  consumer accepts out this cycle.
- out_sel  output  SEL_W  index of the channel that supplied the current out.
- in_data  input  NUM_CH*WIDTH  flattened inputs; channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  input  NUM_CH  per-channel valid.
- in_ready  output  NUM_CH  per-channel ready (combinational).
- sel  input  SEL_W  channel select, used in fixed mode only.
- mode  input  1  0 = fixed select, 1 = round-robin.

Behaviour:
- Reset (rst_n low, asynchronous) clears out, out_valid, out_sel and the rr pointer (ptr) to 0 immediately. Reset asserted mid-transfer discards the held word; no handshake completes in that cycle.
- Register state: one output slot holding out, out_valid and out_sel. No other data storage.
- load_en = !out_valid || out_ready. This permits back-to-back transfers at one word per cycle.
- Grant selection (combinational):
  - Fixed mode: cand = sel. If sel >= NUM_CH there is no candidate and all in_ready are 0.
  - Round-robin mode: cand is the first k with in_valid[k] = 1, searching ptr, ptr+1, … NUM_CH-1, 0, … ptr-1 (wrap-around). If no in_valid bit is set there is no candidate.
- in_ready[cand] = load_en. All other in_ready bits are 0.
  - In fixed mode in_ready[sel] may be 1 while in_valid[sel] = 0.
  - in_ready never depends on in_valid of the same channel in fixed mode.
- Transfer occurs when in_valid[cand] && in_ready[cand]. On the next rising edge:
  - out <= channel cand data;
  - out_sel <= cand;
  - out_valid <= 1.
  - Latency from input handshake to out_valid is exactly 1 cycle.
- Drain without refill: if out_valid && out_ready and no transfer occurs, out_valid <= 0 on the next edge. out and out_sel hold their last values.
- Back-pressure: while out_valid && !out_ready, out, out_sel and out_valid hold and all in_ready bits are 0.
- Pointer update: ptr <= (cand == NUM_CH-1) ? 0 : cand+1, only on a transfer in round-robin mode.
  - ptr is unchanged in fixed mode and on cycles without a transfer.
- Mode change: takes effect combinationally in the same cycle for grant selection. The held output word is unaffected. ptr is retained across fixed-mode periods.
- Simultaneous drain and load in the same cycle: the new word replaces the old one with no bubble.
- Width rule: the data path is a pure copy with no arithmetic. Unused upper sel codes select nothing and are not an error.

Test Plan:
- Reset: drive rst_n low mid-stream with out_valid = 1. Required: out = 0, out_valid = 0, out_sel = 0 and ptr = 0 immediately, before any clk edge.
- Fixed sweep:
  - Setup: mode = 0, NUM_CH = 8, WIDTH = 16, channel k data = 16'h8000 >> k, all in_valid = 1, out_ready = 1.
  - Stimulus: step sel through 0..7, one value per cycle.
  - Required: one cycle later out = 16'h8000, 16'h4000, … 16'h0100 in order, with out_sel = sel; in_ready is one-hot at sel.
- Invalid select and back-pressure:
  - sel = 3'b111 with NUM_CH = 6: all in_ready = 0 and no transfer occurs.
  - Hold out_ready = 0 for 3 cycles after a load: out stays constant, out_valid stays 1 and in_ready stays 0.
- Round-robin fairness:
  - Setup: mode = 1, in_valid = 8'b1010_0101 held, out_ready = 1.
  - Required: out_sel sequence 0, 2, 5, 7, 0, 2, …, with one word per cycle and no bubbles.
- Wrap-around and sparse valids:
  - Setup: mode = 1, ptr at 7 after granting channel 6, in_valid = 8'b0000_0010.
  - Required: grant is channel 1, then ptr = 2.
  - Then set in_valid = 0: out_valid drops to 0 the cycle after the drain.
- Mode switch: after the round-robin grant of channel 3, switch to mode = 0 with sel = 5 for 2 transfers, then return to mode = 1 with all valid. Required: the next round-robin grant is channel 4.
